// File: rtl/fetch_stage_pkg.sv
// Shared widths, reset constants, IF/ID record type and next-state helpers for the fetch stage.
// Included by fetch_stage_if, pc_register and fetch_stage via import fetch_stage_pkg::*.
package fetch_stage_pkg;

    localparam int INST_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;

    localparam logic [ADDR_WIDTH-1:0] PC_RESET_VAL = 32'h0000_0000;
    localparam logic [INST_WIDTH-1:0] NOP_INST_VAL = 32'h0000_0000;

    // HOLD only arises from the illegal pc_write=1/IF_ID_write=0 combination.
    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_STALL = 2'd1,
        ACT_FLUSH = 2'd2,
        ACT_LOAD  = 2'd3
    } fetch_act_e;

    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
        logic [ADDR_WIDTH-1:0] pc4;
        logic                  valid;
    } ifid_t;

    function automatic logic [ADDR_WIDTH-1:0] pc_plus4(input logic [ADDR_WIDTH-1:0] pc);
        return pc + 32'd4;
    endfunction

    // A stall beats a flush: the stalled branch in ID re-resolves next cycle.
    function automatic fetch_act_e decode_act(input logic pc_write,
                                              input logic flush,
                                              input logic ifid_write);
        if (!pc_write)       return ACT_STALL;
        else if (flush)      return ACT_FLUSH;
        else if (ifid_write) return ACT_LOAD;
        else                 return ACT_HOLD;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Hazard-control, instruction-memory and IF/ID signals of the fetch stage.
// slave = fetch_stage side, master = pipeline/environment side.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic                  pc_write;
    logic                  IF_ID_write;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] target_addr;
    logic [INST_WIDTH-1:0] inst_in;
    logic [ADDR_WIDTH-1:0] inst_addr;
    logic [INST_WIDTH-1:0] IF_ID_inst;
    logic [ADDR_WIDTH-1:0] IF_ID_pc4;
    logic                  IF_ID_valid;

    modport slave (
        input  pc_write, IF_ID_write, flush, target_addr, inst_in,
        output inst_addr, IF_ID_inst, IF_ID_pc4, IF_ID_valid
    );

    modport master (
        output pc_write, IF_ID_write, flush, target_addr, inst_in,
        input  inst_addr, IF_ID_inst, IF_ID_pc4, IF_ID_valid
    );

endinterface

// File: rtl/fetch_stage_pc_register.sv
// Program counter: register with asynchronous active-high reset and write enable.
module pc_register
    import fetch_stage_pkg::*;
#(
    parameter int                    WIDTH     = ADDR_WIDTH,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       pc_q <= RESET_VAL;
        else if (we_i) pc_q <= d_i;
    end

    assign q_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, next-PC mux and the IF/ID pipeline register.
// Optional stall/flush performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] PC_RESET = PC_RESET_VAL,
    parameter logic [INST_WIDTH-1:0] NOP_INST = NOP_INST_VAL
) (
    input  logic               clk,
    input  logic               rst,
    fetch_stage_if.slave       bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        flush_cnt
`endif
);

    fetch_act_e            act;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic [ADDR_WIDTH-1:0] pc4;
    ifid_t                 ifid_q;
    ifid_t                 ifid_d;

    assign act  = decode_act(bus.pc_write, bus.flush, bus.IF_ID_write);
    assign pc4  = pc_plus4(pc_q);
    assign pc_d = (act == ACT_FLUSH) ? bus.target_addr : pc4;

    pc_register #(
        .WIDTH     (ADDR_WIDTH),
        .RESET_VAL (PC_RESET)
    ) u_pc (
        .clk  (clk),
        .rst  (rst),
        .we_i (bus.pc_write),
        .d_i  (pc_d),
        .q_o  (pc_q)
    );

    // inst_in only reaches IF/ID on a real load, so X from memory elsewhere is never captured.
    always_comb begin
        ifid_d = ifid_q;
        case (act)
            ACT_FLUSH: ifid_d = '{inst: NOP_INST, pc4: '0, valid: 1'b0};
            ACT_LOAD:  ifid_d = '{inst: bus.inst_in, pc4: pc4, valid: 1'b1};
            default:   ifid_d = ifid_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ifid_q <= '{inst: NOP_INST, pc4: '0, valid: 1'b0};
        else     ifid_q <= ifid_d;
    end

    assign bus.inst_addr   = pc_q;
    assign bus.IF_ID_inst  = ifid_q.inst;
    assign bus.IF_ID_pc4   = ifid_q.pc4;
    assign bus.IF_ID_valid = ifid_q.valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (act == ACT_STALL) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (act == ACT_FLUSH) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

`ifndef SYNTHESIS
    // The hazard unit must stall PC and IF/ID together.
    a_no_ifid_write_on_stall: assert property (
        @(posedge clk) disable iff (rst) !(!bus.pc_write && bus.IF_ID_write));
    a_no_ifid_hold_on_advance: assert property (
        @(posedge clk) disable iff (rst) !(bus.pc_write && !bus.flush && !bus.IF_ID_write));
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: reset, stall, branch flush, wrap and async reset.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    fetch_stage_if bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    fetch_stage dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    // Combinational instruction memory: fixed word at 0, address-tagged words elsewhere.
    assign bus.inst_in = (bus.inst_addr == 32'h0) ? 32'h8C01_0004
                                                  : {16'hA000, bus.inst_addr[15:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ctl(input logic pw, input logic iw, input logic fl, input logic [31:0] tgt);
        bus.pc_write    = pw;
        bus.IF_ID_write = iw;
        bus.flush       = fl;
        bus.target_addr = tgt;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        ctl(1'b1, 1'b1, 1'b0, 32'h0);

        // Reset then run
        tick();
        tick();
        check("rst_inst_addr", bus.inst_addr, 32'h0);
        check("rst_inst", bus.IF_ID_inst, 32'h0);
        check("rst_pc4", bus.IF_ID_pc4, 32'h0);
        check("rst_valid", {31'd0, bus.IF_ID_valid}, 32'd0);
        rst = 1'b0;
        tick();
        check("first_inst", bus.IF_ID_inst, 32'h8C01_0004);
        check("first_pc4", bus.IF_ID_pc4, 32'h4);
        check("first_valid", {31'd0, bus.IF_ID_valid}, 32'd1);
        check("first_addr", bus.inst_addr, 32'h4);
        tick();
        tick();
        tick();
        check("run_addr", bus.inst_addr, 32'h10);
        check("run_inst", bus.IF_ID_inst, 32'hA000_000C);

        // Load-use stall
        ctl(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check("stall_addr", bus.inst_addr, 32'h10);
        check("stall_inst", bus.IF_ID_inst, 32'hA000_000C);
        check("stall_pc4", bus.IF_ID_pc4, 32'h10);
        check("stall_valid", {31'd0, bus.IF_ID_valid}, 32'd1);
        ctl(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        check("unstall_addr", bus.inst_addr, 32'h14);
        check("unstall_inst", bus.IF_ID_inst, 32'hA000_0010);
        check("unstall_pc4", bus.IF_ID_pc4, 32'h14);

        // Taken branch at PC 0x20
        tick();
        tick();
        tick();
        check("pre_br_addr", bus.inst_addr, 32'h20);
        ctl(1'b1, 1'b1, 1'b1, 32'h40);
        tick();
        check("br_addr", bus.inst_addr, 32'h40);
        check("br_inst", bus.IF_ID_inst, 32'h0);
        check("br_pc4", bus.IF_ID_pc4, 32'h0);
        check("br_valid", {31'd0, bus.IF_ID_valid}, 32'd0);
        ctl(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        check("post_br_pc4", bus.IF_ID_pc4, 32'h44);
        check("post_br_inst", bus.IF_ID_inst, 32'hA000_0040);
        check("post_br_valid", {31'd0, bus.IF_ID_valid}, 32'd1);

        // Stall and flush together at PC 0x30
        ctl(1'b1, 1'b1, 1'b1, 32'h2C);
        tick();
        ctl(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        check("sf_pre_addr", bus.inst_addr, 32'h30);
        ctl(1'b0, 1'b0, 1'b1, 32'h80);
        tick();
        check("sf_addr", bus.inst_addr, 32'h30);
        check("sf_inst", bus.IF_ID_inst, 32'hA000_002C);
        check("sf_pc4", bus.IF_ID_pc4, 32'h30);
        check("sf_valid", {31'd0, bus.IF_ID_valid}, 32'd1);
        ctl(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        check("sf_next_addr", bus.inst_addr, 32'h34);

        // Wrap-around; redirect issued with IF_ID_write low still squashes IF/ID
        ctl(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        tick();
        check("wrap_redirect", bus.inst_addr, 32'hFFFF_FFFC);
        check("wrap_squash", {31'd0, bus.IF_ID_valid}, 32'd0);
        ctl(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        check("wrap_pc4", bus.IF_ID_pc4, 32'h0);
        check("wrap_addr", bus.inst_addr, 32'h0);
        check("wrap_inst", bus.IF_ID_inst, 32'hA000_FFFC);

        // Async reset mid-stream after 3 stalls and 2 flushes
        rst = 1'b1;
        ctl(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("cnt_stall_addr", bus.inst_addr, 32'h0);
        ctl(1'b1, 1'b1, 1'b1, 32'h200);
        tick();
        ctl(1'b1, 1'b1, 1'b1, 32'h300);
        tick();
        check("cnt_flush_addr", bus.inst_addr, 32'h300);
`ifdef FETCH_PERF_CNT_EN
        check("stall_cnt", stall_cnt, 32'd3);
        check("flush_cnt", flush_cnt, 32'd2);
`endif
        ctl(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        check("pre_arst_valid", {31'd0, bus.IF_ID_valid}, 32'd1);
        check("pre_arst_addr", bus.inst_addr, 32'h304);
        #2;
        rst = 1'b1;
        #1;
        check("arst_addr", bus.inst_addr, 32'h0);
        check("arst_valid", {31'd0, bus.IF_ID_valid}, 32'd0);
        check("arst_inst", bus.IF_ID_inst, 32'h0);
        check("arst_pc4", bus.IF_ID_pc4, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("arst_stall_cnt", stall_cnt, 32'd0);
        check("arst_flush_cnt", flush_cnt, 32'd0);
`endif
        #1;
        rst = 1'b0;
        tick();
        check("refetch_inst", bus.IF_ID_inst, 32'h8C01_0004);
        check("refetch_pc4", bus.IF_ID_pc4, 32'h4);
        check("refetch_addr", bus.inst_addr, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
